// File: rtl/hp48_bus_ctrl.sv
// hp48_bus_ctrl: bus controller downstream of the Saturn core's command port.
// It holds the PC and DP nibble pointers. Each read or write becomes one
// single-nibble memory transaction with a req/ack handshake. A configurable
// RAM window is decoded against a default ROM region. Protocol faults latch
// a sticky bus_error that only a reset clears.
module hp48_bus_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd,
    input  logic [19:0] address,
    input  logic [3:0]  nibble_in,
    output logic        cmd_ready,
    output logic [3:0]  nibble_out,
    output logic        nibble_valid,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_ram_sel,
    output logic [19:0] mem_addr,
    output logic [3:0]  mem_wdata,
    input  logic [3:0]  mem_rdata,
    input  logic        mem_ack
);

    localparam logic [3:0] CMD_NOP       = 4'd0;
    localparam logic [3:0] CMD_PC_READ   = 4'd1;
    localparam logic [3:0] CMD_DP_READ   = 4'd2;
    localparam logic [3:0] CMD_DP_WRITE  = 4'd3;
    localparam logic [3:0] CMD_LOAD_PC   = 4'd4;
    localparam logic [3:0] CMD_LOAD_DP   = 4'd5;
    localparam logic [3:0] CMD_CONFIGURE = 4'd6;
    localparam logic [3:0] CMD_RESET     = 4'd7;

    // The wait counter faults when it is already at TIMEOUT-1 and another
    // cycle passes with no ack. mem_req is then seen high for exactly
    // TIMEOUT cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t      state;
    logic [19:0] pc_ptr;
    logic [19:0] dp_ptr;
    logic [19:0] ram_mask;
    logic [19:0] ram_base;
    logic        cfg_phase;
    logic        ram_cfgd;
    logic        access_pc;
    logic [7:0]  wait_cnt;

    logic        handshake;
    logic [19:0] issue_addr;
    logic        issue_hit;

    assign handshake = cmd_valid & cmd_ready;

    // Address and RAM-window decode for a memory command presented this cycle
    always_comb begin
        issue_addr = (cmd == CMD_PC_READ) ? pc_ptr : dp_ptr;
        issue_hit  = ram_cfgd && ((issue_addr & ram_mask) == ram_base);
    end

    // Controller FSM: command decode, memory handshake, timeout and fault latch
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            pc_ptr       <= '0;
            dp_ptr       <= '0;
            ram_mask     <= '0;
            ram_base     <= '0;
            cfg_phase    <= 1'b0;
            ram_cfgd     <= 1'b0;
            access_pc    <= 1'b0;
            wait_cnt     <= '0;
            cmd_ready    <= 1'b0;
            nibble_out   <= '0;
            nibble_valid <= 1'b0;
            bus_error    <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_ram_sel  <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            nibble_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (handshake) begin
                        case (cmd)
                            CMD_NOP: ;
                            CMD_LOAD_PC: pc_ptr <= address;
                            CMD_LOAD_DP: dp_ptr <= address;
                            CMD_CONFIGURE: begin
                                if (!cfg_phase) begin
                                    ram_mask  <= address;
                                    cfg_phase <= 1'b1;
                                end else begin
                                    ram_base  <= address & ram_mask;
                                    ram_cfgd  <= 1'b1;
                                    cfg_phase <= 1'b0;
                                end
                            end
                            CMD_RESET: begin
                                ram_cfgd  <= 1'b0;
                                cfg_phase <= 1'b0;
                            end
                            CMD_PC_READ, CMD_DP_READ: begin
                                mem_req     <= 1'b1;
                                mem_we      <= 1'b0;
                                mem_addr    <= issue_addr;
                                mem_ram_sel <= issue_hit;
                                access_pc   <= (cmd == CMD_PC_READ);
                                wait_cnt    <= '0;
                                cmd_ready   <= 1'b0;
                                state       <= ACCESS;
                            end
                            CMD_DP_WRITE: begin
                                cmd_ready <= 1'b0;
                                if (issue_hit) begin
                                    mem_req     <= 1'b1;
                                    mem_we      <= 1'b1;
                                    mem_addr    <= issue_addr;
                                    mem_wdata   <= nibble_in;
                                    mem_ram_sel <= 1'b1;
                                    access_pc   <= 1'b0;
                                    wait_cnt    <= '0;
                                    state       <= ACCESS;
                                end else begin
                                    // ROM is read-only: refuse without touching the bus
                                    bus_error <= 1'b1;
                                    state     <= FAULT;
                                end
                            end
                            default: begin
                                bus_error <= 1'b1;
                                cmd_ready <= 1'b0;
                                state     <= FAULT;
                            end
                        endcase
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                        if (!mem_we) begin
                            nibble_out   <= mem_rdata;
                            nibble_valid <= 1'b1;
                        end
                        if (access_pc) begin
                            pc_ptr <= pc_ptr + 20'd1;
                        end else begin
                            dp_ptr <= dp_ptr + 20'd1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_req   <= 1'b0;
                        bus_error <= 1'b1;
                        state     <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                FAULT: begin
                    cmd_ready <= 1'b0;
                    mem_req   <= 1'b0;
                end
                default: begin
                    cmd_ready <= 1'b0;
                    mem_req   <= 1'b0;
                    bus_error <= 1'b1;
                    state     <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hp48_bus_ctrl.sv
// Bench for hp48_bus_ctrl: a directed vector table, multi-cycle corner
// sequences, and random commands checked against a pointer/window model.
module tb_hp48_bus_ctrl;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic [3:0]  cmd;
    logic [19:0] address;
    logic [3:0]  nibble_in;
    logic        cmd_ready;
    logic [3:0]  nibble_out;
    logic        nibble_valid;
    logic        bus_error;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ram_sel;
    logic [19:0] mem_addr;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    hp48_bus_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .address(address), .nibble_in(nibble_in), .cmd_ready(cmd_ready),
        .nibble_out(nibble_out), .nibble_valid(nibble_valid),
        .bus_error(bus_error), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ram_sel(mem_ram_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [19:0] a;
        logic [3:0]  n;
        int          d;     // ack delay in cycles after the first request cycle
        logic [3:0]  r;
        bit          mem;   // a memory transaction is expected
        logic [19:0] ea;
        bit          esel;
        bit          ewe;
        logic [3:0]  en;    // expected nibble_out (read) or mem_wdata (write)
        bit          eerr;  // command must fault
    } vec_t;

    // Reference model state
    logic [19:0] m_pc, m_dp, m_mask, m_base;
    bit          m_cfg, m_phase;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [3:0] c, input logic [19:0] a, input logic [3:0] n,
                               input int d, input logic [3:0] r, input bit mem,
                               input logic [19:0] ea, input bit esel, input bit ewe,
                               input logic [3:0] en, input bit eerr);
        vec_t t;
        t.c = c; t.a = a; t.n = n; t.d = d; t.r = r; t.mem = mem;
        t.ea = ea; t.esel = esel; t.ewe = ewe; t.en = en; t.eerr = eerr;
        return t;
    endfunction

    function automatic vec_t vreg(input logic [3:0] c, input logic [19:0] a);
        return v(c, a, 4'h0, 0, 4'h0, 1'b0, 20'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; cmd_valid = 1'b0; mem_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst outs", {12'h0, mem_req, mem_we, mem_ram_sel, nibble_valid, bus_error, nibble_out, mem_wdata}, 32'h0);
        chk("rst mem_addr", 32'(mem_addr), 32'h0);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post-rst cmd_ready", 32'(cmd_ready), 32'h1);
        m_pc = '0; m_dp = '0; m_mask = '0; m_base = '0; m_cfg = 0; m_phase = 0;
    endtask

    task automatic issue(input logic [3:0] c, input logic [19:0] a, input logic [3:0] n, output bit ok);
        int w;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(posedge clk); @(negedge clk);
            w++;
        end
        ok = (cmd_ready === 1'b1);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL handshake: cmd_ready=%0b after 50 cycles, required 1", cmd_ready);
            return;
        end
        cmd_valid = 1'b1; cmd = c; address = a; nibble_in = n;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0; cmd = 4'h0;
    endtask

    task automatic run_txn(input vec_t t, input string tag);
        bit ok;
        issue(t.c, t.a, t.n, ok);
        if (!ok) return;
        if (t.eerr) begin
            chk({tag, " fault req"}, 32'(mem_req), 32'h0);
            chk({tag, " fault err"}, 32'(bus_error), 32'h1);
            chk({tag, " fault ready"}, 32'(cmd_ready), 32'h0);
        end else if (!t.mem) begin
            chk({tag, " reg ready"}, 32'(cmd_ready), 32'h1);
            chk({tag, " reg err"}, 32'(bus_error), 32'h0);
        end else begin
            for (int k = 0; k <= t.d; k++) begin
                chk({tag, " req"}, 32'(mem_req), 32'h1);
                chk({tag, " addr"}, 32'(mem_addr), 32'(t.ea));
                chk({tag, " sel/we"}, {30'h0, mem_ram_sel, mem_we}, {30'h0, t.esel, t.ewe});
                if (t.ewe) chk({tag, " wdata"}, 32'(mem_wdata), 32'(t.en));
                if (k == t.d) begin
                    mem_ack = 1'b1; mem_rdata = t.r;
                end
                @(posedge clk); @(negedge clk);
                mem_ack = 1'b0;
            end
            chk({tag, " nvalid"}, 32'(nibble_valid), 32'(!t.ewe));
            if (!t.ewe) chk({tag, " nibble_out"}, 32'(nibble_out), 32'(t.en));
            chk({tag, " done ready/req/err"}, {29'h0, cmd_ready, mem_req, bus_error}, 32'h4);
        end
        $display("txn %s cmd=%0h addr=%05h delay=%0d -> mem_addr=%05h sel=%0b we=%0b nout=%0h err=%0b",
                 tag, t.c, t.a, t.d, mem_addr, mem_ram_sel, mem_we, nibble_out, bus_error);
    endtask

    function automatic bit m_hit(input logic [19:0] x);
        return m_cfg && ((x & m_mask) == m_base);
    endfunction

    // Random command plus its expected outcome from the model
    task automatic gen(output vec_t t);
        logic [31:0] rnd;
        logic [19:0] a;
        logic [3:0]  n, r;
        int          pick, d;
        logic [19:0] masks [4];
        masks[0] = 20'hF0000; masks[1] = 20'hFC000; masks[2] = 20'hFFF00; masks[3] = 20'h00000;
        rnd = $urandom; a = rnd[19:0];
        rnd = $urandom; n = rnd[3:0]; r = rnd[7:4];
        d = $urandom_range(0, 4);
        pick = $urandom_range(0, 11);
        if ($urandom_range(0, 1) == 0) a = m_base | {12'h0, a[7:0]};
        if ($urandom_range(0, 9) == 0) a = 20'hFFFFE | {19'h0, a[0]};
        t = vreg(4'h0, a);
        case (pick)
            0: t = vreg(4'h0, a);
            1, 2: begin
                t = v(4'h1, a, n, d, r, 1'b1, m_pc, m_hit(m_pc), 1'b0, r, 1'b0);
                m_pc = m_pc + 20'd1;
            end
            3, 4: begin
                t = v(4'h2, a, n, d, r, 1'b1, m_dp, m_hit(m_dp), 1'b0, r, 1'b0);
                m_dp = m_dp + 20'd1;
            end
            5, 6: begin
                if (m_hit(m_dp)) begin
                    t = v(4'h3, a, n, d, r, 1'b1, m_dp, 1'b1, 1'b1, n, 1'b0);
                    m_dp = m_dp + 20'd1;
                end else begin
                    t = v(4'h3, a, n, d, r, 1'b0, 20'h0, 1'b0, 1'b0, 4'h0, 1'b1);
                end
            end
            7: begin t = vreg(4'h4, a); m_pc = a; end
            8, 9: begin t = vreg(4'h5, a); m_dp = a; end
            10: begin
                if (!m_phase) begin
                    a = masks[$urandom_range(0, 3)];
                    m_mask = a; m_phase = 1;
                end else begin
                    m_base = a & m_mask; m_cfg = 1; m_phase = 0;
                end
                t = vreg(4'h6, a);
            end
            default: begin t = vreg(4'h7, a); m_cfg = 0; m_phase = 0; end
        endcase
    endtask

    vec_t tbl[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   cnt;
        vec_t t;
        reset = 1'b0; cmd_valid = 1'b0; cmd = 4'h0; address = '0;
        nibble_in = 4'h0; mem_rdata = 4'h0; mem_ack = 1'b0;

        // Directed vectors: c, a, n, d, r, mem, ea, esel, ewe, en, eerr
        tbl.push_back(vreg(4'h4, 20'h00100));
        tbl.push_back(v(4'h1, 20'h0, 4'h0, 0, 4'h2, 1, 20'h00100, 0, 0, 4'h2, 0));
        tbl.push_back(v(4'h1, 20'h0, 4'h0, 0, 4'h3, 1, 20'h00101, 0, 0, 4'h3, 0));
        tbl.push_back(v(4'h1, 20'h0, 4'h0, 1, 4'h4, 1, 20'h00102, 0, 0, 4'h4, 0));
        tbl.push_back(v(4'h1, 20'h0, 4'h0, 0, 4'h9, 1, 20'h00103, 0, 0, 4'h9, 0));
        tbl.push_back(vreg(4'h4, 20'hFFFFF));
        tbl.push_back(v(4'h1, 20'h0, 4'h0, 0, 4'h7, 1, 20'hFFFFF, 0, 0, 4'h7, 0));
        tbl.push_back(v(4'h1, 20'h0, 4'h0, 2, 4'h1, 1, 20'h00000, 0, 0, 4'h1, 0));
        tbl.push_back(vreg(4'h6, 20'hFC000));
        tbl.push_back(vreg(4'h6, 20'h80000));
        tbl.push_back(vreg(4'h5, 20'h80010));
        tbl.push_back(v(4'h3, 20'h0, 4'hA, 0, 4'h0, 1, 20'h80010, 1, 1, 4'hA, 0));
        tbl.push_back(v(4'h2, 20'h0, 4'h0, 0, 4'h5, 1, 20'h80011, 1, 0, 4'h5, 0));
        tbl.push_back(vreg(4'h5, 20'h70000));
        tbl.push_back(v(4'h2, 20'h0, 4'h0, 1, 4'h6, 1, 20'h70000, 0, 0, 4'h6, 0));
        tbl.push_back(vreg(4'h7, 20'h0));
        tbl.push_back(vreg(4'h5, 20'h80010));
        tbl.push_back(v(4'h2, 20'h0, 4'h0, 0, 4'hB, 1, 20'h80010, 0, 0, 4'hB, 0));
        tbl.push_back(vreg(4'h0, 20'h12345));
        tbl.push_back(vreg(4'h5, 20'h00000));
        tbl.push_back(v(4'h3, 20'h0, 4'h3, 0, 4'h0, 0, 20'h0, 0, 0, 4'h0, 1));

        apply_reset();
        foreach (tbl[i]) run_txn(tbl[i], $sformatf("dir%0d", i));
        // The fault from the last vector must hold until reset
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("fault hold ready/req/err", {29'h0, cmd_ready, mem_req, bus_error}, 32'h1);
        end

        // Timeout: PC_READ with no ack
        apply_reset();
        run_txn(vreg(4'h4, 20'h00042), "to_load");
        issue(4'h1, 20'h0, 4'h0, ok);
        cnt = 0;
        while (mem_req === 1'b1 && cnt < 40) begin
            cnt++;
            @(posedge clk); @(negedge clk);
        end
        chk("timeout req cycles", 32'(cnt), 32'd15);
        chk("timeout err/ready", {30'h0, bus_error, cmd_ready}, 32'h2);
        chk("timeout pc_ptr", 32'(dut.pc_ptr), 32'h00042);
        mem_ack = 1'b1; mem_rdata = 4'h5;
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b0;
        chk("late ack ignored", {30'h0, nibble_valid, mem_req}, 32'h0);
        $display("txn timeout req_cycles=%0d err=%0b", cnt, bus_error);

        // Illegal command code
        apply_reset();
        run_txn(v(4'h9, 20'h0, 4'h0, 0, 4'h0, 0, 20'h0, 0, 0, 4'h0, 1), "illegal9");

        // Reset during ACCESS with the ack arriving one cycle later
        apply_reset();
        run_txn(vreg(4'h4, 20'h00100), "mid_load");
        issue(4'h1, 20'h0, 4'h0, ok);
        chk("mid req", 32'(mem_req), 32'h1);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 4'hF;
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b0;
        chk("mid outs", {12'h0, mem_req, mem_we, mem_ram_sel, nibble_valid, bus_error, nibble_out, mem_wdata}, 32'h0);
        chk("mid mem_addr", 32'(mem_addr), 32'h0);
        chk("mid ready", 32'(cmd_ready), 32'h1);
        chk("mid pc_ptr", 32'(dut.pc_ptr), 32'h0);
        $display("txn reset_mid_access req=%0b nvalid=%0b pc=%05h", mem_req, nibble_valid, dut.pc_ptr);

        // Random commands against the model
        apply_reset();
        for (int i = 0; i < 150; i++) begin
            gen(t);
            run_txn(t, $sformatf("rnd%0d", i));
            if (bus_error === 1'b1 || t.eerr) apply_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hp48_bus_ctrl.md
# hp48_bus_ctrl

Bus controller sitting directly downstream of the Saturn core's bus-command port. It accepts one nibble-granular command at a time, owns the PC and data-pointer (DP) address registers, and translates reads and writes into single-nibble memory transactions with a request/acknowledge handshake. It decodes one configurable RAM window plus a default ROM region, and reports protocol faults on a sticky `bus_error`.

## Interface
- `TIMEOUT`, 15: cycles `mem_req` may wait for `mem_ack` before a fault; 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low.
- `cmd_valid`  in  1  core presents a command.
- `cmd`  in  4  command code: NOP=0, PC_READ=1, DP_READ=2, DP_WRITE=3, LOAD_PC=4, LOAD_DP=5, CONFIGURE=6, RESET=7; 8..F illegal.
- `address`  in  20  operand for LOAD_PC, LOAD_DP, CONFIGURE.
- `nibble_in`  in  4  write data for DP_WRITE.
- `cmd_ready`  out  1  controller can accept a command this cycle.
- `nibble_out`  out  4  read data, valid with `nibble_valid`.
- `nibble_valid`  out  1  one-cycle pulse on read completion.
- `bus_error`  out  1  sticky fault flag.
- `mem_req`  out  1  memory request, held until ack.
- `mem_we`  out  1  write qualifier, stable with `mem_req`.
- `mem_ram_sel`  out  1  1 = RAM window, 0 = ROM.
- `mem_addr`  out  20  nibble address, stable with `mem_req`.
- `mem_wdata`  out  4  write nibble, stable with `mem_req`.
- `mem_rdata`  in  4  read nibble, sampled on `mem_ack`.
- `mem_ack`  in  1  one-cycle completion from memory.

## Operation
- Registers: `pc_ptr`[19:0], `dp_ptr`[19:0], `ram_mask`[19:0], `ram_base`[19:0], `cfg_phase` (0 = expect size, 1 = expect base), `ram_cfgd`.
- States: IDLE, ACCESS, FAULT.
- IDLE: `cmd_ready`=1. Handshake `cmd_valid & cmd_ready`:
  - NOP: no effect, stay IDLE.
  - LOAD_PC: `pc_ptr <= address`. LOAD_DP: `dp_ptr <= address`. Stay IDLE.
  - CONFIGURE: phase 0 → `ram_mask <= address`, phase 1; phase 1 → `ram_base <= address & ram_mask`, `ram_cfgd <= 1`, phase 0.
  - RESET: `ram_cfgd <= 0`, phase 0; pointers unchanged.
  - PC_READ: issue read at `pc_ptr` → ACCESS. DP_READ / DP_WRITE: issue read/write at `dp_ptr` → ACCESS.
  - Illegal code: `bus_error <= 1` → FAULT.
- Decode: `mem_ram_sel = ram_cfgd & ((addr & ram_mask) == ram_base)`, registered at issue. DP_WRITE decoding to ROM: no request, `bus_error <= 1` → FAULT.
- ACCESS: `cmd_ready`=0, `mem_req`=1. On `mem_ack`: read → `nibble_out <= mem_rdata`, `nibble_valid` pulse; PC access → `pc_ptr + 1`, DP access → `dp_ptr + 1`; → IDLE.
- Pointer arithmetic modulo 2^20: FFFFF+1 = 00000, no error.
- Timeout: counter clears at issue, counts each ACCESS cycle without ack; at `TIMEOUT` → `bus_error <= 1`, drop `mem_req`, → FAULT, pointer not incremented.
- FAULT: `cmd_ready`=0, no requests; exits only on reset. `mem_ack` outside ACCESS ignored.

## Timing
- Reset (`reset`=0 at edge) clears everything regardless of state: state IDLE, `cmd_ready`=0 during reset cycle then 1, all pointers/mask/base 0, `ram_cfgd`=0, phase 0, `mem_req`=0, `mem_we`=0, `mem_ram_sel`=0, `mem_addr`=0, `mem_wdata`=0, `nibble_out`=0, `nibble_valid`=0, `bus_error`=0. Reset mid-ACCESS drops `mem_req` next cycle; pending ack is ignored.
- Register commands: take effect the edge after handshake; back-to-back accepted every cycle.
- Memory command accepted at edge N: `mem_req` high from N+1; ack at edge N+k → `nibble_valid` and pointer update visible after N+k, `cmd_ready` high in the same cycle; next command accepted at N+k+1 earliest. Minimum read latency: 2 cycles (ack in first request cycle).
- `mem_addr/we/wdata/ram_sel` constant while `mem_req`=1.
- Timeout: with no ack, `bus_error` rises after edge N+TIMEOUT.

## Test plan
- Reset then LOAD_PC 00100, three PC_READ with 1-cycle acks returning 2,3,4 → `nibble_out` 2,3,4 with three pulses, `mem_addr` 00100/00101/00102, `pc_ptr`=00103.
- LOAD_PC FFFFF, PC_READ → `mem_addr`=FFFFF, `pc_ptr` wraps to 00000, `bus_error`=0.
- CONFIGURE FC000, CONFIGURE 80000, LOAD_DP 80010, DP_WRITE nibble A → `mem_ram_sel`=1, `mem_we`=1, `mem_wdata`=A, `dp_ptr`=80011; DP_READ at 70000 → `mem_ram_sel`=0.
- Unconfigured, DP_WRITE to 00000 → no `mem_req`, `bus_error`=1, `cmd_ready`=0 until reset.
- PC_READ with no ack, `TIMEOUT`=15 → `mem_req` high 15 cycles, then `bus_error`=1, `pc_ptr` unchanged; illegal cmd 9 → `bus_error`=1.
- Reset asserted during ACCESS, ack on next cycle → all outputs at reset values, no `nibble_valid`, `pc_ptr`=0.
